fetch_unit: RTL

//   Consumer side of the next-PC path. Holds the architectural PC and issues one instruction-memory read at a time.

---
 rtl/cpu_defs.sv | 17 +
 rtl/fetch_buf.sv | 44 ++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared fetch-path constants and fetch FSM state encoding
package cpu_defs;

  localparam int          CPU_ADDR_W   = 32;
  localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic pc_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - one-entry {pc, instr, adel} holding register facing decode
module fetch_buf
  import cpu_defs::*;
#(
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [31:0]       load_instr,
  input  logic              load_adel,
  input  logic              ready,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  output logic              adel
);

  // Flush wins over load so a redirect can never leave a stale entry visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
      adel  <= 1'b0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
      if (load) begin
        pc    <= load_pc;
        instr <= load_instr;
        adel  <= load_adel;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - architectural PC, single-outstanding imem fetch FSM, decode handoff
module fetch_unit
  import cpu_defs::*;
#(
  parameter int              ADDR_W   = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] npc_in,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  output logic              if_adel
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              misaligned;
  logic              buf_load, buf_flush;
  logic [31:0]       load_instr;
  logic              load_adel;

  assign misaligned = pc_misaligned(pc_q[1:0]);
  assign imem_addr  = pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    imem_req   = 1'b0;
    buf_load   = 1'b0;
    buf_flush  = 1'b0;
    load_instr = imem_rdata;
    load_adel  = 1'b0;
    case (state_q)
      FS_REQ: begin
        if (misaligned) begin
          if (!redirect) begin
            buf_load   = 1'b1;
            load_instr = '0;
            load_adel  = 1'b1;
            pc_d       = pc_q + PC_STEP;
            state_d    = FS_HOLD;
          end
        end else begin
          imem_req = !reset;
          if (imem_req && imem_gnt) begin
            state_d = FS_WAIT;
            drop_d  = redirect;
          end
        end
      end
      FS_WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          if (drop_q || redirect) begin
            state_d = FS_REQ;
          end else begin
            buf_load = 1'b1;
            pc_d     = pc_q + PC_STEP;
            state_d  = FS_HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      FS_HOLD: begin
        // The next request overlaps the cycle decode takes the buffer.
        if (redirect) begin
          buf_flush = 1'b1;
          state_d   = FS_REQ;
        end else if (if_ready) begin
          imem_req = !reset && !misaligned;
          state_d  = (imem_req && imem_gnt) ? FS_WAIT : FS_REQ;
        end
      end
      default: state_d = FS_REQ;
    endcase
    if (redirect) begin
      pc_d = npc_in;
    end
  end

  fetch_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .flush      (buf_flush),
    .load_pc    (pc_q),
    .load_instr (load_instr),
    .load_adel  (load_adel),
    .ready      (if_ready),
    .valid      (if_valid),
    .pc         (if_pc),
    .instr      (if_instr),
    .adel       (if_adel)
  );

endmodule
